// File: rtl/sc_pkg.sv
// Shared constants and helpers for the stochastic-computing blocks.
package sc_pkg;

    localparam int DEFAULT_DIMENSION = 4;
    localparam int DEFAULT_WIDTH     = 8;

    // Pipeline fill tracking; saturates at FILL_FULL until the next reset.
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_state_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_dot_product_unit_if.sv
// Stream bundle between the SNG/counter front end and the dot-product engine.
interface sc_dot_product_unit_if
    import sc_pkg::*;
#(
    parameter int DIMENSION = DEFAULT_DIMENSION,
    parameter int SEL_WIDTH = clog2(DIMENSION)
);

    logic [DIMENSION-1:0] data;
    logic [DIMENSION-1:0] weights;
    logic [SEL_WIDTH-1:0] sel;
    logic                 result;
    logic                 valid;

    modport master (
        output data,
        output weights,
        output sel,
        input  result,
        input  valid
    );

    modport slave (
        input  data,
        input  weights,
        input  sel,
        output result,
        output valid
    );

endinterface

// File: rtl/sc_mux_adder.sv
// Scaled stochastic adder: one lane picked by sel each cycle, output registered.
module sc_mux_adder
    import sc_pkg::*;
#(
    parameter int DIMENSION = DEFAULT_DIMENSION,
    parameter int SEL_WIDTH = clog2(DIMENSION)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIMENSION-1:0] lanes,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic                 result
);

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 1'b0;
        end else begin
            result <= lanes[sel];
        end
    end

endmodule

// File: rtl/sc_dot_product_unit.sv
// Stochastic dot product: lane-wise AND multiply, then mux-adder scaled sum.
module sc_dot_product_unit
    import sc_pkg::*;
#(
    parameter int DIMENSION = DEFAULT_DIMENSION,
    parameter int SEL_WIDTH = clog2(DIMENSION)
) (
    input logic                clk,
    input logic                rst,
    sc_dot_product_unit_if.slave bus
);

    logic [DIMENSION-1:0] prod;
    logic [SEL_WIDTH-1:0] sel_q;
    logic                 result_q;
    fill_state_e          fill_state;

    // sel travels with the products so each select picks the lane it was issued with.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod  <= '0;
            sel_q <= '0;
        end else begin
            prod  <= bus.data & bus.weights;
            sel_q <= bus.sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_state <= FILL_EMPTY;
        end else begin
            case (fill_state)
                FILL_EMPTY: fill_state <= FILL_ONE;
                FILL_ONE:   fill_state <= FILL_FULL;
                default:    fill_state <= FILL_FULL;
            endcase
        end
    end

    sc_mux_adder #(
        .DIMENSION (DIMENSION),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_mux_adder (
        .clk    (clk),
        .rst    (rst),
        .lanes  (prod),
        .sel    (sel_q),
        .result (result_q)
    );

    assign bus.result = result_q;
    assign bus.valid  = (fill_state == FILL_FULL);

endmodule

// File: tb/tb_sc_dot_product_unit.sv
// Directed self-checking bench for sc_dot_product_unit.
module tb_sc_dot_product_unit;
    import sc_pkg::*;

    localparam int DIM = DEFAULT_DIMENSION;
    localparam int SW  = clog2(DIM);

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sel_cnt;
    logic [7:0]    lfsr_a;
    logic [7:0]    lfsr_b;
    logic [DIM-1:0] one_hot;
    int            tests = 0;
    int            fails = 0;
    int            ones;

    sc_dot_product_unit_if #(.DIMENSION(DIM), .SEL_WIDTH(SW)) bus ();

    sc_dot_product_unit #(
        .DIMENSION (DIM),
        .SEL_WIDTH (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [DIM-1:0] d, input logic [DIM-1:0] w,
                                  input logic [SW-1:0] s);
        bus.data    = d;
        bus.weights = w;
        bus.sel     = s;
    endtask

    task automatic check_output(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus('0, '0, '0);
        tick();
        check_output("reset_result", bus.result, 1'b0);
        check_output("reset_valid", bus.valid, 1'b0);
        rst     = 1'b0;
        sel_cnt = '0;
    endtask

    // Two different primitive polynomials keep the data and weight streams uncorrelated.
    function automatic logic [7:0] lfsr_a_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] lfsr_b_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[2]};
    endfunction

    initial begin
        rst     = 1'b1;
        sel_cnt = '0;
        apply_stimulus('0, '0, '0);
        tick();

        // All-ones: result and valid rise together two edges after release.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(4'b1111, 4'b1111, sel_cnt);
            sel_cnt = sel_cnt + 1'b1;
            tick();
            check_output("ones_result", bus.result, k >= 2);
            check_output("ones_valid", bus.valid, k >= 2);
        end

        // Reset mid-stream while all-ones is still flowing.
        rst = 1'b1;
        tick();
        check_output("midrst_result", bus.result, 1'b0);
        check_output("midrst_valid", bus.valid, 1'b0);
        rst = 1'b0;
        tick();
        check_output("midrst_fill_result", bus.result, 1'b0);
        check_output("midrst_fill_valid", bus.valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(4'b1111, 4'b1111, sel_cnt);
            sel_cnt = sel_cnt + 1'b1;
            tick();
            check_output("midrst_back_result", bus.result, 1'b1);
            check_output("midrst_back_valid", bus.valid, 1'b1);
        end

        // All-zero weights: result stays low, valid still asserts at latency 2.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(4'b1111, 4'b0000, sel_cnt);
            sel_cnt = sel_cnt + 1'b1;
            tick();
            check_output("zeros_result", bus.result, 1'b0);
            check_output("zeros_valid", bus.valid, k >= 2);
        end

        // Single lane 2: products only on lane 2, one hit every four cycles.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            apply_stimulus(4'b0101, 4'b0110, sel_cnt);
            sel_cnt = sel_cnt + 1'b1;
            tick();
            check_output("lane2_result", bus.result, (k % 4) == 0);
            check_output("lane2_valid", bus.valid, k >= 2);
        end

        // Mixed lanes: products 4'b1010, so odd lanes fire as sel sweeps.
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            apply_stimulus(4'b1011, 4'b1110, sel_cnt);
            sel_cnt = sel_cnt + 1'b1;
            tick();
            check_output("mixed_result", bus.result, (k >= 2) && ((k % 2) == 1));
        end

        // One-hot lane tracking sel: only a correctly aligned sel pipeline yields ones.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            one_hot          = '0;
            one_hot[sel_cnt] = 1'b1;
            apply_stimulus(one_hot, one_hot, sel_cnt);
            sel_cnt = sel_cnt + 1'b1;
            tick();
            check_output("align_result", bus.result, k >= 2);
        end

        // Statistical: data 240, weights 202 from LFSR-driven SNGs.
        do_reset();
        lfsr_a = 8'hC3;
        lfsr_b = 8'h81;
        ones   = 0;
        for (int k = 1; k <= 257; k++) begin
            apply_stimulus({DIM{lfsr_a < 8'd240}}, {DIM{lfsr_b < 8'd202}}, sel_cnt);
            lfsr_a  = lfsr_a_next(lfsr_a);
            lfsr_b  = lfsr_b_next(lfsr_b);
            sel_cnt = sel_cnt + 1'b1;
            tick();
            if (k == 2) begin
                check_output("stat_valid", bus.valid, 1'b1);
            end
            if (k >= 2 && bus.result === 1'b1) begin
                ones++;
            end
        end
        tests++;
        assert (ones >= 181 && ones <= 197)
        else begin
            fails++;
            $error("[TB] FAIL stat_ones: observed %0d expected 189 +/- 8", ones);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
